// File: rtl/mul_32bit_seq_pkg.sv
// Shared ALU package: multiplier FSM state encoding and iteration limit.
package mul_32bit_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } mul_state_e;

    localparam logic [4:0] MUL_ITER_LAST = 5'd31;

endpackage

// File: rtl/mul_32bit_seq_add.sv
// add_32bit: 32-bit adder with carry in/out, the single adder of the ALU
// multiplier.
module add_32bit (
    input  logic [31:0] X,
    input  logic [31:0] Y,
    input  logic        C_IN,
    output logic [31:0] Z,
    output logic        C_OUT
);

    assign {C_OUT, Z} = {1'b0, X} + {1'b0, Y} + {32'b0, C_IN};

endmodule

// File: rtl/mul_32bit_seq.sv
// Sequential unsigned 32x32->64 shift-and-add multiplier on one add_32bit.
// Define MUL_ZERO_SKIP_EN to finish zero-operand multiplies in one cycle.
module mul_32bit_seq
    import mul_32bit_seq_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic [31:0] X,
    input  logic [31:0] Y,
    output logic        BUSY,
    output logic        DONE,
    output logic [63:0] P
);

    mul_state_e  state_q, state_d;
    logic [31:0] a_q, a_d;
    logic [31:0] h_q, h_d;
    logic [31:0] q_q, q_d;
    logic [4:0]  cnt_q, cnt_d;

    logic [31:0] add_s;
    logic        add_c;
    logic        accept;
    logic        zero_op;

    add_32bit u_add (
        .X     (h_q),
        .Y     (a_q),
        .C_IN  (1'b0),
        .Z     (add_s),
        .C_OUT (add_c)
    );

    assign accept = START && (state_q != RUN);

`ifdef MUL_ZERO_SKIP_EN
    assign zero_op = (X == 32'd0) || (Y == 32'd0);
`else
    assign zero_op = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            a_q     <= '0;
            h_q     <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            h_q     <= h_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, FIN: begin
                if (accept)
                    state_d = zero_op ? FIN : RUN;
                else
                    state_d = IDLE;
            end
            RUN: begin
                if (cnt_q == MUL_ITER_LAST)
                    state_d = FIN;
            end
            default: state_d = IDLE;
        endcase
    end

    // Adder carry becomes bit 31 of the shifted accumulator.
    always_comb begin
        a_d   = a_q;
        h_d   = h_q;
        q_d   = q_q;
        cnt_d = cnt_q;
        if (accept) begin
            a_d   = X;
            h_d   = '0;
            q_d   = zero_op ? 32'd0 : Y;
            cnt_d = '0;
        end else if (state_q == RUN) begin
            if (q_q[0]) begin
                h_d = {add_c, add_s[31:1]};
                q_d = {add_s[0], q_q[31:1]};
            end else begin
                h_d = {1'b0, h_q[31:1]};
                q_d = {h_q[0], q_q[31:1]};
            end
            cnt_d = cnt_q + 5'd1;
        end
    end

    always_comb begin
        BUSY = (state_q == RUN);
        DONE = (state_q == FIN);
        P    = {h_q, q_q};
    end

endmodule
